lifo_stack: RTL and testbench
=============================

LIFO_STACK -- requirements
Module: lifo_stack

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, setting the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, setting the number of entries; it SHALL be a power of two and at least 2.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: push  input  1  push request.
REQ-006 Port: pop  input  1  pop request.
REQ-007 Port: data_in  input  DATA_WIDTH  word written on an accepted push.
REQ-008 Port: data_out  output  DATA_WIDTH  registered; holds the most recently popped word.
REQ-009 Port: error  output  1  registered; flags a rejected operation (overflow, underflow, or conflict).

Function
REQ-010 The block SHALL be a last-in-first-out store with an occupancy count of 0..DEPTH; count and storage SHALL start empty after reset.
REQ-011 A push request with count<DEPTH SHALL write data_in to entry[count] at the clock edge, increment count, and clear error.
REQ-012 A pop request with count>0 SHALL load entry[count-1] into data_out at the clock edge, decrement count, and clear error; data_out is valid in the cycle after the edge (1-cycle latency).
REQ-013 A push request with count==DEPTH (overflow) SHALL leave count, storage and data_out unchanged and set error=1.
REQ-014 A pop request with count==0 (underflow) SHALL leave count, storage and data_out unchanged and set error=1.
REQ-015 Push and pop requests in the same cycle SHALL be rejected as a conflict: no state change except error=1.
REQ-016 Once set, error SHALL remain 1 through idle cycles until the next accepted push/pop or reset.
REQ-017 With no request, all state, data_out and error SHALL hold.
REQ-018 data_out SHALL NOT change on a push; the storage entries SHALL NOT be readable except through pop.
REQ-019 A request SHALL be determined per cycle as defined in the Configuration section (edge or level qualified).

Reset
REQ-020 While reset=1, count=0, data_out=0, error=0, and the push/pop history registers=0, independent of clk.
REQ-021 Reset asserted mid-operation SHALL discard all stored words; storage contents need not be cleared.
REQ-022 No request SHALL be accepted on a clock edge at which reset is asserted.

Configuration
REQ-023 Macro LIFO_STACK_EDGE_OPS_EN SHALL select request qualification.
REQ-024 With LIFO_STACK_EDGE_OPS_EN defined, a request SHALL occur only in a cycle where the input is 1 and was 0 in the previous cycle (registered history); holding push or pop high for N cycles SHALL perform exactly one operation.
REQ-025 Without LIFO_STACK_EDGE_OPS_EN, a request SHALL occur in every cycle the input is sampled 1; holding push for N cycles SHALL perform N pushes (with overflow once full).
REQ-026 For single-cycle pulses separated by at least one idle cycle, both builds SHALL behave identically.

Verification
REQ-027 Reset, then push 0x00..0x0F as 1-cycle pulses with idle gaps -> count 16, error=0 throughout.
REQ-028 From full, one extra push of 0x00 -> error=1 next cycle, count stays 16; then 16 pop pulses -> data_out reads 0x0F, 0x0E, ... 0x00, and error=0 after the first pop.
REQ-029 From empty, one pop pulse -> error=1 next cycle, data_out holds 0x00; a subsequent push of 0xFF clears error.
REQ-030 Reset, push 0xFF, idle one cycle, pop -> data_out=0xFF one cycle after the pop edge, error=0.
REQ-031 Reset, hold push=1 with data_in=0xFF for 3000 cycles, then hold pop=1 for 3000 cycles -> EDGE build: one push, one pop (data_out=0xFF), error=0; level build: 16 pushes then error=1, then 16 pops then error=1.
REQ-032 Assert push and pop together with 3 entries stored -> error=1, count 3, data_out unchanged; assert reset asynchronously mid-sequence -> data_out=0, error=0 immediately.

Source files
------------

// File: rtl/lifo_stack.sv
// ---------------------------------------------------------------------------
// lifo_stack
//
// Purpose : Last-in-first-out word store with registered read data and a
//           sticky error flag for rejected operations (overflow, underflow,
//           or a push and a pop requested in the same cycle).
//
// Configuration macro:
//   LIFO_STACK_EDGE_OPS_EN  defined   -> a request is a 0->1 transition of
//                                        push/pop (one operation per assertion)
//                           undefined -> a request is every cycle push/pop is 1
//
// Ports:
//   clk       in   rising-edge clock for all state
//   reset     in   asynchronous, active-high reset
//   push      in   push request
//   pop       in   pop request
//   data_in   in   [DATA_WIDTH] word written on an accepted push
//   data_out  out  [DATA_WIDTH] registered, most recently popped word
//   error     out  registered, set by a rejected request, cleared by an
//                  accepted one, held otherwise
// ---------------------------------------------------------------------------
module lifo_stack #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  error
);

    localparam int ADDR_W  = $clog2(DEPTH);
    // One extra bit so the count can represent DEPTH itself (full).
    localparam int COUNT_W = $clog2(DEPTH + 1);
    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("lifo_stack: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [COUNT_W-1:0]    count;

    logic push_req;
    logic pop_req;

`ifdef LIFO_STACK_EDGE_OPS_EN
    // Previous-cycle samples of the request inputs; a request is a rising
    // edge, so holding an input high performs exactly one operation.
    logic push_q;
    logic pop_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            push_q <= 1'b0;
            pop_q  <= 1'b0;
        end else begin
            push_q <= push;
            pop_q  <= pop;
        end
    end

    assign push_req = push & ~push_q;
    assign pop_req  = pop  & ~pop_q;
`else
    assign push_req = push;
    assign pop_req  = pop;
`endif

    logic full;
    logic empty;
    logic push_ok;
    logic pop_ok;
    logic rejected;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    // Simultaneous push and pop is a conflict: neither side is accepted.
    assign push_ok = push_req & ~pop_req & ~full;
    assign pop_ok  = pop_req  & ~push_req & ~empty;
    assign rejected = (push_req | pop_req) & ~push_ok & ~pop_ok;

    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] rd_idx;

    // When count < DEPTH, its low bits address the next free entry; when
    // count > 0, count-1 addresses the top of stack.
    assign wr_idx = ADDR_W'(count);
    assign rd_idx = ADDR_W'(count - COUNT_W'(1));

    // NOTE: storage has no reset; emptiness is tracked by count alone, so the
    // array maps onto plain RAM without a per-entry clear network.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_idx] <= data_in;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            data_out <= '0;
            error    <= 1'b0;
        end else begin
            if (push_ok) begin
                count <= count + COUNT_W'(1);
                error <= 1'b0;
            end else if (pop_ok) begin
                count    <= count - COUNT_W'(1);
                data_out <= mem[rd_idx];
                error    <= 1'b0;
            end else if (rejected) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lifo_stack.sv
// ---------------------------------------------------------------------------
// tb_lifo_stack
//
// Purpose : Directed self-checking bench for lifo_stack (DATA_WIDTH=8,
//           DEPTH=16). Expectations for held-request behaviour follow the
//           LIFO_STACK_EDGE_OPS_EN build selection.
// ---------------------------------------------------------------------------
module tb_lifo_stack;

`ifdef LIFO_STACK_EDGE_OPS_EN
    localparam bit EDGE_BUILD = 1'b1;
`else
    localparam bit EDGE_BUILD = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       push;
    logic       pop;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       error;

    int checks;
    int errors;

    lifo_stack #(
        .DATA_WIDTH(8),
        .DEPTH     (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .data_in (data_in),
        .data_out(data_out),
        .error   (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs at the falling edge, let one rising edge pass, and
    // return 1 time unit later so outputs are sampled away from the edge.
    task automatic drive(input logic p, input logic q, input logic [7:0] d);
        @(negedge clk);
        push    = p;
        pop     = q;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic push_pulse(input logic [7:0] d);
        drive(1'b1, 1'b0, d);
        drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic pop_pulse();
        drive(1'b0, 1'b1, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        push  = 1'b0;
        pop   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = 8'h00;
        #12;
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_data_out: got %h expected %h", data_out, 8'h00);
        end
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL reset_error: got %b expected %b", error, 1'b0);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Fill, overflow, drain in LIFO order, underflow, recovery push.
    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            push_pulse(8'(i));
            checks++;
            if (error !== 1'b0) begin
                errors++;
                $display("FAIL fill_error[%0d]: got %b expected %b", i, error, 1'b0);
            end
            checks++;
            if (data_out !== 8'h00) begin
                errors++;
                $display("FAIL fill_data_out[%0d]: got %h expected %h", i, data_out, 8'h00);
            end
        end

        drive(1'b1, 1'b0, 8'h00);
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL overflow_error: got %b expected %b", error, 1'b1);
        end
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL overflow_error_sticky: got %b expected %b", error, 1'b1);
        end
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL overflow_data_out: got %h expected %h", data_out, 8'h00);
        end

        for (int i = 0; i < 16; i++) begin
            pop_pulse();
            checks++;
            if (data_out !== 8'(15 - i)) begin
                errors++;
                $display("FAIL drain_data_out[%0d]: got %h expected %h", i, data_out, 8'(15 - i));
            end
            checks++;
            if (error !== 1'b0) begin
                errors++;
                $display("FAIL drain_error[%0d]: got %b expected %b", i, error, 1'b0);
            end
        end

        pop_pulse();
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL underflow_error: got %b expected %b", error, 1'b1);
        end
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL underflow_data_out: got %h expected %h", data_out, 8'h00);
        end

        push_pulse(8'hFF);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL recover_push_error: got %b expected %b", error, 1'b0);
        end
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL push_keeps_data_out: got %h expected %h", data_out, 8'h00);
        end
        pop_pulse();
        checks++;
        if (data_out !== 8'hFF) begin
            errors++;
            $display("FAIL recover_pop_data: got %h expected %h", data_out, 8'hFF);
        end
    endtask

    task automatic test_single();
        apply_reset();
        push_pulse(8'hFF);
        drive(1'b0, 1'b1, 8'h00);
        checks++;
        if (data_out !== 8'hFF) begin
            errors++;
            $display("FAIL single_data_out: got %h expected %h", data_out, 8'hFF);
        end
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL single_error: got %b expected %b", error, 1'b0);
        end
        drive(1'b0, 1'b0, 8'h00);
    endtask

    // Held requests: records the first cycle in each phase where error is 1.
    task automatic test_hold();
        int first_push_err;
        int first_pop_err;
        int exp_first;
        first_push_err = 0;
        first_pop_err  = 0;
        exp_first      = EDGE_BUILD ? 0 : 17;
        apply_reset();

        for (int i = 1; i <= 3000; i++) begin
            drive(1'b1, 1'b0, 8'hFF);
            if (error === 1'b1 && first_push_err == 0) first_push_err = i;
        end
        checks++;
        if (first_push_err !== exp_first) begin
            errors++;
            $display("FAIL hold_push_first_error_cycle: got %0d expected %0d", first_push_err, exp_first);
        end

        for (int i = 1; i <= 3000; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            if (error === 1'b1 && first_pop_err == 0) first_pop_err = i;
        end
        checks++;
        if (first_pop_err !== exp_first) begin
            errors++;
            $display("FAIL hold_pop_first_error_cycle: got %0d expected %0d", first_pop_err, exp_first);
        end
        checks++;
        if (data_out !== 8'hFF) begin
            errors++;
            $display("FAIL hold_data_out: got %h expected %h", data_out, 8'hFF);
        end
        checks++;
        if (error !== !EDGE_BUILD) begin
            errors++;
            $display("FAIL hold_final_error: got %b expected %b", error, !EDGE_BUILD);
        end

        // Stack must be empty in both builds now.
        drive(1'b0, 1'b0, 8'h00);
        pop_pulse();
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL hold_empty_after: got %b expected %b", error, 1'b1);
        end
    endtask

    task automatic test_conflict();
        apply_reset();
        push_pulse(8'h11);
        push_pulse(8'h22);
        push_pulse(8'h33);
        push_pulse(8'h44);
        pop_pulse();
        checks++;
        if (data_out !== 8'h44) begin
            errors++;
            $display("FAIL conflict_setup_data: got %h expected %h", data_out, 8'h44);
        end

        drive(1'b1, 1'b1, 8'h99);
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL conflict_error: got %b expected %b", error, 1'b1);
        end
        drive(1'b0, 1'b0, 8'h00);
        checks++;
        if (data_out !== 8'h44) begin
            errors++;
            $display("FAIL conflict_data_out: got %h expected %h", data_out, 8'h44);
        end

        // Exactly three entries must remain, in order.
        for (int i = 0; i < 3; i++) begin
            pop_pulse();
            checks++;
            if (data_out !== 8'(8'h33 - 8'(i) * 8'h11)) begin
                errors++;
                $display("FAIL conflict_pop[%0d]: got %h expected %h", i, data_out, 8'(8'h33 - 8'(i) * 8'h11));
            end
        end
        pop_pulse();
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL conflict_count3: got %b expected %b", error, 1'b1);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        push_pulse(8'h55);
        push_pulse(8'h66);
        pop_pulse();
        drive(1'b1, 1'b1, 8'h00);
        checks++;
        if (error !== 1'b1 || data_out !== 8'h66) begin
            errors++;
            $display("FAIL async_setup: got %b/%h expected %b/%h", error, data_out, 1'b1, 8'h66);
        end
        push = 1'b0;
        pop  = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_data_out: got %h expected %h", data_out, 8'h00);
        end
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_error: got %b expected %b", error, 1'b0);
        end

        // A push on an edge while reset is held must be ignored.
        drive(1'b1, 1'b0, 8'h77);
        @(negedge clk);
        reset = 1'b0;
        push  = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 8'h00);
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL reset_discards_error: got %b expected %b", error, 1'b1);
        end
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_discards_data: got %h expected %h", data_out, 8'h00);
        end
        drive(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fill_drain();
        test_single();
        test_hold();
        test_conflict();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
